// File: rtl/flopenr_pipe.sv
// rtl/flopenr_pipe.sv - DEPTH-stage enabled register chain with valid flags, flush and bubble compaction
// Output-side stall lets words keep moving into empty downstream stages until they pack at the output.
module flopenr_pipe #(
   parameter int               WIDTH     = 16,
   parameter int               DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         en,
   input  logic                         clr,
   input  logic                         in_valid,
   input  logic [WIDTH-1:0]             d,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             q,
   output logic                         out_valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [DEPTH-1:0] move;

   // A stage may load when everything downstream of it moves or it is itself empty.
   always_comb begin : move_chain
      logic m;
      m    = en;
      move = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         m       = m | ~valid_q[i];
         move[i] = m;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (move[0]) begin
         valid_d[0] = in_valid;
         if (in_valid) data_d[0] = d;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (move[i]) begin
            valid_d[i] = valid_q[i-1];
            if (valid_q[i-1]) data_d[i] = data_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
      end else if (clr) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_VAL;
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
      end
   end

   always_comb begin
      count = '0;
      for (int i = 0; i < DEPTH; i++) count = count + CW'(valid_q[i]);
   end

   assign in_ready  = move[0];
   assign q         = data_q[DEPTH-1];
   assign out_valid = valid_q[DEPTH-1];

endmodule
